// File: rtl/avalon_mm_burst_slave_if.sv
// ---------------------------------------------------------------------------
// avalon_mm_burst_slave_if
//
// Avalon-MM bus bundle between one initiator and one burst-capable slave.
//
// Signals:
//   address            word address of the command (first beat of a burst)
//   byteenable         per-byte write enable
//   writedata          write data
//   read / write       command strobes (write also marks write-burst beats)
//   burstcount         beats in the burst, 0 behaves as 1
//   beginbursttransfer informational burst-start marker
//   readdata           read data, valid while readdatavalid is high
//   waitrequest        slave stall
//   readdatavalid      one pulse per returned read beat
//
// Modports:
//   master  initiator side (drives the command, receives responses)
//   slave   responder side (receives the command, drives responses)
// ---------------------------------------------------------------------------
interface avalon_mm_burst_slave_if #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8
);

  logic [NBADDRBITS-1:0]    address;
  logic [NBDATABYTES-1:0]   byteenable;
  logic [8*NBDATABYTES-1:0] writedata;
  logic                     read;
  logic                     write;
  logic [7:0]               burstcount;
  logic                     beginbursttransfer;
  logic [8*NBDATABYTES-1:0] readdata;
  logic                     waitrequest;
  logic                     readdatavalid;

  modport master (
    output address, byteenable, writedata, read, write, burstcount,
           beginbursttransfer,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, read, write, burstcount,
           beginbursttransfer,
    output readdata, waitrequest, readdatavalid
  );

endinterface

// File: rtl/avalon_mm_burst_slave.sv
// ---------------------------------------------------------------------------
// avalon_mm_burst_slave
//
// Avalon-MM responder backed by an internal word-addressed memory. Supports
// programmable wait states, fixed-latency pipelined reads, burst reads and
// writes (addresses wrap at the top of memory), byte-enabled writes, and a
// sticky flag for initiator protocol violations.
//
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous active-high reset (memory is not cleared)
//   bus             avalon_mm_burst_slave_if.slave bundle
//   protocol_error  sticky flag, set on an initiator violation, cleared by rst
//
// Parameters:
//   NBDATABYTES  data bus width in bytes
//   NBADDRBITS   word address width (depth = 2**NBADDRBITS)
//   WAITSTATES   waitrequest-high cycles per command before acceptance (0..15)
//   READLATENCY  cycles from read acceptance to first readdatavalid (1..8)
// ---------------------------------------------------------------------------
module avalon_mm_burst_slave #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int WAITSTATES  = 1,
  parameter int READLATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  avalon_mm_burst_slave_if.slave bus,
  output logic                   protocol_error
);

  localparam int DW    = 8 * NBDATABYTES;
  localparam int DEPTH = 1 << NBADDRBITS;

  // waitrequest level while parked in IDLE
  localparam logic IDLE_WR = (WAITSTATES > 0);
  // Cycles still to spend with waitrequest high after the first IDLE cycle
  localparam logic [3:0] WAIT_INIT = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;
  // Idle latency cycles between acceptance and issuing the first read beat
  localparam logic [2:0] LAT_INIT = (READLATENCY > 1) ? 3'(READLATENCY - 2) : 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    WR_BURST,
    RD_LAT,
    RD_BURST
  } state_t;

  state_t                  state_reg;
  logic [3:0]              wait_cnt_reg;
  logic [2:0]              lat_cnt_reg;
  logic [7:0]              beats_left_reg;
  logic [NBADDRBITS-1:0]   cur_addr_reg;
  logic [NBADDRBITS-1:0]   hold_addr_reg;
  logic [7:0]              hold_bc_reg;
  logic                    waitrequest_reg;
  logic                    readdatavalid_reg;
  logic                    protocol_error_reg;

  logic                    cmd_present;
  logic                    accept;
  logic [7:0]              bc_eff;

  logic                    mem_wr_en;
  logic [NBADDRBITS-1:0]   mem_wr_addr;
  logic                    mem_rd_en;
  logic [NBADDRBITS-1:0]   mem_rd_addr;
  logic [DW-1:0]           rd_data;

  // beginbursttransfer carries no information the datapath needs
  logic                    unused_bbt;
  assign unused_bbt = bus.beginbursttransfer;

  assign cmd_present = bus.read | bus.write;
  // A command is taken in any IDLE/WAIT cycle where the slave is not stalling.
  // With WAITSTATES>0 waitrequest is only low in the final WAIT cycle.
  assign accept = !waitrequest_reg && cmd_present &&
                  ((state_reg == IDLE) || (state_reg == WAIT));
  assign bc_eff = (bus.burstcount == 8'd0) ? 8'd1 : bus.burstcount;

  // -------------------------------------------------------------------------
  // Memory port strobes. A beat is written on its own edge so any later read
  // sees it. When read and write arrive together the write wins.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = cur_addr_reg;
    mem_rd_en   = 1'b0;
    mem_rd_addr = cur_addr_reg;
    if (!rst) begin
      if (accept && bus.write) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = bus.address;
      end
      if ((state_reg == WR_BURST) && bus.write) begin
        mem_wr_en = 1'b1;
      end
      if (accept && !bus.write && (READLATENCY == 1)) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = bus.address;
      end
      if ((state_reg == RD_LAT) && (lat_cnt_reg == 3'd0)) begin
        mem_rd_en = 1'b1;
      end
      if ((state_reg == RD_BURST) && (beats_left_reg != 8'd0)) begin
        mem_rd_en = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM. In the read states beats_left_reg counts beats not yet
  // issued; readdatavalid is registered alongside the memory read register
  // so both land in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      wait_cnt_reg       <= 4'd0;
      lat_cnt_reg        <= 3'd0;
      beats_left_reg     <= 8'd0;
      cur_addr_reg       <= '0;
      hold_addr_reg      <= '0;
      hold_bc_reg        <= 8'd0;
      waitrequest_reg    <= 1'b1;
      readdatavalid_reg  <= 1'b0;
      protocol_error_reg <= 1'b0;
    end else begin
      readdatavalid_reg <= 1'b0;

      if (bus.read && bus.write) begin
        protocol_error_reg <= 1'b1;
      end
      // The stalled command must stay put until it is taken
      if ((state_reg == WAIT) &&
          ((bus.address != hold_addr_reg) || (bus.burstcount != hold_bc_reg))) begin
        protocol_error_reg <= 1'b1;
      end

      if (accept) begin
        if (bus.write) begin
          cur_addr_reg   <= bus.address + 1'b1;
          beats_left_reg <= bc_eff - 8'd1;
          if (bc_eff > 8'd1) begin
            state_reg       <= WR_BURST;
            waitrequest_reg <= 1'b0;
          end else begin
            state_reg       <= IDLE;
            waitrequest_reg <= IDLE_WR;
          end
        end else begin
          waitrequest_reg <= 1'b1;
          if (READLATENCY == 1) begin
            readdatavalid_reg <= 1'b1;
            cur_addr_reg      <= bus.address + 1'b1;
            beats_left_reg    <= bc_eff - 8'd1;
            state_reg         <= RD_BURST;
          end else begin
            cur_addr_reg   <= bus.address;
            beats_left_reg <= bc_eff;
            lat_cnt_reg    <= LAT_INIT;
            state_reg      <= RD_LAT;
          end
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (cmd_present && (WAITSTATES > 0)) begin
              state_reg       <= WAIT;
              wait_cnt_reg    <= WAIT_INIT;
              waitrequest_reg <= (WAIT_INIT != 4'd0);
              hold_addr_reg   <= bus.address;
              hold_bc_reg     <= bus.burstcount;
            end else begin
              waitrequest_reg <= IDLE_WR;
            end
          end

          WAIT: begin
            if (wait_cnt_reg != 4'd0) begin
              wait_cnt_reg    <= wait_cnt_reg - 4'd1;
              waitrequest_reg <= (wait_cnt_reg != 4'd1);
            end else begin
              // Command withdrawn during the acceptance cycle: drop it
              state_reg       <= IDLE;
              waitrequest_reg <= IDLE_WR;
            end
          end

          WR_BURST: begin
            if (bus.write) begin
              cur_addr_reg   <= cur_addr_reg + 1'b1;
              beats_left_reg <= beats_left_reg - 8'd1;
              if (beats_left_reg == 8'd1) begin
                state_reg       <= IDLE;
                waitrequest_reg <= IDLE_WR;
              end
            end
          end

          RD_LAT: begin
            if (lat_cnt_reg == 3'd0) begin
              readdatavalid_reg <= 1'b1;
              cur_addr_reg      <= cur_addr_reg + 1'b1;
              beats_left_reg    <= beats_left_reg - 8'd1;
              state_reg         <= RD_BURST;
            end else begin
              lat_cnt_reg <= lat_cnt_reg - 3'd1;
            end
          end

          RD_BURST: begin
            if (beats_left_reg != 8'd0) begin
              readdatavalid_reg <= 1'b1;
              cur_addr_reg      <= cur_addr_reg + 1'b1;
              beats_left_reg    <= beats_left_reg - 8'd1;
            end else begin
              state_reg       <= IDLE;
              waitrequest_reg <= IDLE_WR;
            end
          end

          default: begin
            state_reg       <= IDLE;
            waitrequest_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane so byteenable maps to independent
  // write enables. Read is registered and holds its value between beats.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NBDATABYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (mem_wr_en && bus.byteenable[gi]) begin
          mem[mem_wr_addr] <= bus.writedata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_byte_reg <= 8'd0;
        end else if (mem_rd_en) begin
          rd_byte_reg <= mem[mem_rd_addr];
        end
      end

      assign rd_data[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  assign bus.readdata      = rd_data;
  assign bus.waitrequest   = waitrequest_reg;
  assign bus.readdatavalid = readdatavalid_reg;
  assign protocol_error    = protocol_error_reg;

endmodule
